// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the opcode constants, the fetch FSM state encoding and small helper
// functions that slice an instruction word into opcode / field A / B / C.
// Instruction layout: opcode [27:24], A [23:16], B [15:8], C [7:0].
package instruction_fetch_sequencer_pkg;

  localparam int INSTR_W = 28;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_STO  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_RET  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_BLE  = 4'd7;
  localparam logic [3:0] OP_LED  = 4'd8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[27:24];
  endfunction

  function automatic logic [7:0] field_a_of(input logic [INSTR_W-1:0] instr);
    return instr[23:16];
  endfunction

  function automatic logic [7:0] field_b_of(input logic [INSTR_W-1:0] instr);
    return instr[15:8];
  endfunction

  function automatic logic [7:0] field_c_of(input logic [INSTR_W-1:0] instr);
    return instr[7:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_return_address_stack.sv
// Return-address stack: synchronous LIFO used by CALL/RET.
// Ports:
//   Clock, Reset (sync, active-low) - clocking / count reset
//   iPush, iData                    - push iData on the rising edge
//   iPop                            - pop the top entry on the rising edge
//   oData                           - current top of stack (valid same cycle)
//   oFull, oEmpty                   - occupancy status
// Push/pop requests against a full/empty stack are ignored; the caller is
// expected to detect those cases from oFull/oEmpty.
module return_address_stack #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic [ADDR_WIDTH-1:0] iData,
  output logic [ADDR_WIDTH-1:0] oData,
  output logic                  oFull,
  output logic                  oEmpty
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]      count_q;
  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      top_idx;
  logic                  do_push;
  logic                  do_pop;

  assign oFull   = (count_q == CNT_W'(STACK_DEPTH));
  assign oEmpty  = (count_q == '0);
  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = PTR_W'(count_q - CNT_W'(1));
  assign oData   = mem[top_idx];
  assign do_push = iPush && !oFull;
  assign do_pop  = iPop && !oEmpty && !iPush;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage carries no reset: only entries below count_q are ever read.
  always_ff @(posedge Clock) begin
    if (Reset && do_push) begin
      mem[wr_idx] <= iData;
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction ROM and
// registers each fetched word into a one-stage fetch/execute pipeline.
// JMP/CALL/RET resolve at fetch (CALL/RET via the return-address stack);
// BLE resolves at execute from iBranchTaken and squashes the wrong-path fetch.
// Ports:
//   Clock, Reset (sync, active-low)
//   iInstruction      - combinational ROM data for oAddress
//   iStall            - datapath hold request (freezes everything)
//   iBranchTaken      - BLE outcome for the word on oInstruction
//   oAddress          - ROM address (the PC register)
//   oInstruction      - registered instruction for execute
//   oInstructionValid - oInstruction is to be executed
//   oHalted           - sequencer is in ERROR
//   oStackOverflow    - sticky, CALL with a full stack
//   oStackUnderflow   - sticky, RET with an empty stack
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28,
  parameter int STACK_DEPTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oInstructionValid,
  output logic                   oHalted,
  output logic                   oStackOverflow,
  output logic                   oStackUnderflow
);

  fetch_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]  pc_p0, pc_d, pc_inc;
  logic [INSTR_WIDTH-1:0] instr_p1, instr_d;
  logic                   vld_p1, vld_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   push, pop;
  logic                   stk_full, stk_empty;
  logic [ADDR_WIDTH-1:0]  stk_top;
  logic                   squash;

  function automatic logic [ADDR_WIDTH-1:0] zext_target(input logic [7:0] a);
    return {{(ADDR_WIDTH-8){1'b0}}, a};
  endfunction

  assign pc_inc = pc_p0 + ADDR_WIDTH'(1);

  // A taken BLE sitting in execute redirects fetch and kills this cycle's word.
  assign squash = vld_p1 && (opcode_of(instr_p1) == OP_BLE) && iBranchTaken;

  return_address_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ras (
    .Clock (Clock),
    .Reset (Reset),
    .iPush (push),
    .iPop  (pop),
    .iData (pc_inc),
    .oData (stk_top),
    .oFull (stk_full),
    .oEmpty(stk_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    instr_d = instr_p1;
    vld_d   = vld_p1;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      ST_ERROR: begin
        vld_d = 1'b0;
      end
      default: begin
        if (!iStall) begin
          instr_d = iInstruction;
          vld_d   = 1'b1;
          if (squash) begin
            pc_d  = zext_target(field_a_of(instr_p1));
            vld_d = 1'b0;
          end else begin
            case (opcode_of(iInstruction))
              OP_CALL: begin
                if (stk_full) begin
                  ovf_d   = 1'b1;
                  state_d = ST_ERROR;
                  vld_d   = 1'b0;
                end else begin
                  push = 1'b1;
                  pc_d = zext_target(field_a_of(iInstruction));
                end
              end
              OP_RET: begin
                if (stk_empty) begin
                  unf_d   = 1'b1;
                  state_d = ST_ERROR;
                  vld_d   = 1'b0;
                end else begin
                  pop  = 1'b1;
                  pc_d = stk_top;
                end
              end
              OP_JMP:  pc_d = zext_target(field_a_of(iInstruction));
              default: pc_d = pc_inc;
            endcase
          end
        end
      end
    endcase
  end

  // ---- fetch (p0) / execute (p1) register boundary ----
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= ST_RUN;
      pc_p0    <= '0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_d;
      instr_p1 <= instr_d;
      vld_p1   <= vld_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign oAddress          = pc_p0;
  assign oInstruction      = instr_p1;
  assign oInstructionValid = vld_p1;
  assign oHalted           = (state_q == ST_ERROR);
  assign oStackOverflow    = ovf_q;
  assign oStackUnderflow   = unf_q;

endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
Reader side of the 28-bit instruction ROM. Owns the program counter, drives the ROM address, and registers each fetched instruction into a one-stage fetch/execute pipeline for the datapath. Resolves JMP, CALL and RET at fetch through a hardware return-address stack; resolves BLE at execute through a datapath flag, squashing the wrong-path instruction. Sits between the ROM and the ALU/register-file datapath.

Parameters:
ADDR_WIDTH, 16, ROM address / PC width
INSTR_WIDTH, 28, instruction width: opcode [27:24], field A [23:16], B [15:8], C [7:0]
STACK_DEPTH, 8, return-address stack entries (power of 2)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low
iInstruction  in  INSTR_WIDTH  combinational ROM data for oAddress
iStall  in  1  datapath hold request
iBranchTaken  in  1  BLE condition result for the instruction currently on oInstruction
oAddress  out  ADDR_WIDTH  ROM address, equal to the PC register
oInstruction  out  INSTR_WIDTH  registered instruction for execute
oInstructionValid  out  1  oInstruction is to be executed
oHalted  out  1  sequencer is in ERROR
oStackOverflow  out  1  sticky, CALL issued with stack full
oStackUnderflow  out  1  sticky, RET issued with stack empty

Behaviour:
- Reset (Reset=0 at the edge): PC=0, oInstruction=0, oInstructionValid=0, stack pointer=0, oHalted=0, both error flags=0, state=RUN. Reset has priority over everything, including mid-CALL and in ERROR.
- States: RUN and ERROR. RUN -> ERROR on overflow or underflow. ERROR exits only through reset.
- RUN, iStall=0, no squash. Each edge: oInstruction <= iInstruction, oInstructionValid <= 1, PC <= next PC.
  - CALL: push PC+1, then PC <= zero-extended field A.
  - RET: PC <= popped address.
  - JMP: PC <= zero-extended field A.
  - All other opcodes, including BLE: PC <= PC+1.
  - Flow-control instructions still go to execute with valid=1. The datapath treats them as no-ops.
- BLE resolution: evaluated when oInstructionValid=1, oInstruction opcode=BLE, iStall=0.
  - If iBranchTaken=1: PC <= zero-extended field A of oInstruction. The instruction fetched this cycle is squashed: oInstructionValid <= 0, and it causes no push, pop or PC update (including CALL/RET/JMP).
  - If iBranchTaken=0: normal sequencing.
- Stall: iStall=1 holds PC, oInstruction, oInstructionValid and the stack. iBranchTaken is ignored while stalled. Stall has priority over branch.
- Overflow: CALL while the stack holds STACK_DEPTH entries.
  - No push, and PC is unchanged.
  - oStackOverflow <= 1, state <= ERROR.
  - The CALL is not forwarded: oInstructionValid <= 0.
- Underflow: RET with an empty stack. Same handling as overflow, but oStackUnderflow is set.
- ERROR: oHalted=1, oInstructionValid=0, PC and stack frozen, all inputs ignored.
- Arithmetic: PC+1 is modulo 2^ADDR_WIDTH (16'hFFFF -> 0). Pushed return addresses are the full ADDR_WIDTH. Field A targets reach only 0..255.
- Latency: ROM address to valid oInstruction is 1 cycle. Taken BLE costs 1 bubble. JMP, CALL and RET cost 0 bubbles.

Decomposition:
- Opcode constants (NOP, STO, ADD, SUB, CALL, RET, JMP, BLE, LED) remain in the shared definitions header.
- Add to the same header: field-slice macros (OPCODE, FIELD_A, FIELD_B, FIELD_C) and the state encoding.
- One sub-module: return_address_stack.
  - Synchronous LIFO with push, pop, data in/out, full and empty.
  - Same Clock/Reset convention.
  - Pop data is valid in the same cycle (read from top-of-stack register).

Test Plan:
- Straight-line program, release reset -> oAddress 0,1,2,3 on consecutive cycles; oInstruction lags by one cycle; oInstructionValid rises on the first edge after reset release.
- CALL 222 at address 3, ADD at 222, RET at 223 -> oAddress 3,222,223,4; stack depth 1 then 0; no invalid cycles.
- BLE at 5 (target 10), iBranchTaken=1 while BLE is on oInstruction -> instruction from address 6 has oInstructionValid=0; next oAddress=10. Repeat with iBranchTaken=0 -> address 6 executes.
- 8 nested CALLs, then a 9th -> oStackOverflow=1, oHalted=1, PC frozen at the 9th CALL's address, valid=0. Separately, RET after reset -> oStackUnderflow=1, PC stays at the RET address.
- iStall=1 for 3 cycles mid-sequence (including while a taken BLE is on oInstruction) -> oAddress and oInstruction constant, no squash until the stall drops, then the branch resolves once.
- Reset asserted one cycle after a CALL, and separately while in ERROR -> PC=0, stack empty, flags cleared, fetch resumes from 0.
